// File: rtl/uart_pkg.sv
// Shared receive-path definitions: field widths, status bit positions and the
// capture FSM state type used by the Rx FIFO.
package uart_pkg;

  localparam int RX_STAT_W  = 3;
  localparam int RX_DATA_W  = 8;
  localparam int RX_ENTRY_W = RX_STAT_W + RX_DATA_W;

  // Bit positions inside the {OVF,FERR,PERR} status field
  localparam int ST_PERR = 0;
  localparam int ST_FERR = 1;
  localparam int ST_OVF  = 2;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_WAIT = 1'b1
  } cap_state_t;

endpackage

// File: rtl/rx_fifo_buffer_if.sv
// Bundles the engine-side handshake and the host-side FWFT read port of the Rx FIFO.
interface rx_fifo_buffer_if #(
  parameter int ADDR_W = 4
);
  import uart_pkg::*;

  logic                 RXRDY;
  logic [RX_DATA_W-1:0] UART_RDATA;
  logic [RX_STAT_W-1:0] RX_Status;
  logic                 Read;
  logic                 rd_en;
  logic [RX_DATA_W-1:0] rd_data;
  logic [RX_STAT_W-1:0] rd_status;
  logic                 empty;
  logic                 full;
  logic                 almost_full;
  logic [ADDR_W:0]      count;
  logic                 hold;

  // master: engine + host side driving the buffer; slave: the buffer itself
  modport master (
    output RXRDY, UART_RDATA, RX_Status, rd_en,
    input  Read, rd_data, rd_status, empty, full, almost_full, count, hold
  );

  modport slave (
    input  RXRDY, UART_RDATA, RX_Status, rd_en,
    output Read, rd_data, rd_status, empty, full, almost_full, count, hold
  );

endinterface

// File: rtl/rx_fifo_mem.sv
// Entry storage for the Rx FIFO: synchronous write, asynchronous read so the
// head entry can fall through to the host without a read cycle.
module rx_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo_buffer.sv
// Rx-side FIFO: captures one {status,byte} per RXRDY assertion from the engine
// and presents the queue to the host in first-word-fall-through form.
module rx_fifo_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input logic            clk,
  input logic            rst,
  rx_fifo_buffer_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_LEVEL);

  cap_state_t              state, state_nxt;
  logic                    wr, pop, read_q;
  logic [ADDR_W-1:0]       wr_ptr, rd_ptr;
  logic [ADDR_W:0]         count_q, count_nxt;
  logic                    empty_q, full_q, af_q;
  logic [RX_ENTRY_W-1:0]   head;

  // Capture decision uses the registered full flag, so a pop and a pending
  // write while full resolve as pop-now, write-next-cycle.
  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    case (state)
      CAP_IDLE: begin
        if (bus.RXRDY && !full_q) begin
          wr        = 1'b1;
          state_nxt = CAP_WAIT;
        end
      end
      CAP_WAIT: begin
        if (!bus.RXRDY) state_nxt = CAP_IDLE;
      end
      default: state_nxt = CAP_IDLE;
    endcase
  end

  assign pop = bus.rd_en && !empty_q;

  always_comb begin
    count_nxt = count_q;
    if (wr && !pop)      count_nxt = count_q + 1'b1;
    else if (pop && !wr) count_nxt = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CAP_IDLE;
      read_q  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      read_q  <= wr;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == FULL_CNT);
      af_q    <= (count_nxt >= AF_CNT);
    end
  end

  rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (RX_ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata ({bus.RX_Status, bus.UART_RDATA}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.Read        = read_q;
  assign bus.count       = count_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.hold        = bus.RXRDY && full_q;
  // Head outputs are zeroed while empty so stale storage never leaks out
  assign bus.rd_data     = empty_q ? '0 : head[RX_DATA_W-1:0];
  assign bus.rd_status   = empty_q ? '0 : head[RX_ENTRY_W-1:RX_DATA_W];

endmodule
